branch_hazard_ctrl: RTL
=======================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 Param ADDR_WIDTH, default 32, width of pc and target addresses.
REQ-002 Param FLUSH_CYCLES, default 2, cycles flush is held after a taken branch; legal range 1..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 inst  in  32  instruction word presented by inst_fetch.
REQ-007 pc  in  ADDR_WIDTH  address of inst.
REQ-008 inst_valid  in  1  inst/pc valid this cycle.
REQ-009 resolve_valid  in  1  execute stage reports branch outcome.
REQ-010 resolve_taken  in  1  outcome; qualified by resolve_valid.
REQ-011 resolve_target  in  ADDR_WIDTH  taken target; qualified by resolve_valid.
REQ-012 stall_fetch  out  1  hold fetch PC/instruction.
REQ-013 flush  out  1  kill younger in-flight instructions.
REQ-014 redirect_valid  out  1  one-cycle pulse, load redirect_pc into fetch.
REQ-015 redirect_pc  out  ADDR_WIDTH  new fetch address.
REQ-016 branch_pc  out  ADDR_WIDTH  pc of the outstanding branch.

Function
REQ-017 Branch decode: primary opcode inst[0:5] (PowerPC bit order) = 18 (b), 16 (bc), or 19 with XO inst[21:30] = 16 (bclr) or 528 (bcctr); all else non-branch.
REQ-018 FSM states IDLE, WAIT_RESOLVE, FLUSH; all outputs registered.
REQ-019 IDLE: inst_valid and branch -> capture pc into branch_pc, next WAIT_RESOLVE; otherwise stay.
REQ-020 IDLE: resolve_valid ignored, no output change.
REQ-021 WAIT_RESOLVE: stall_fetch=1; inst_valid ignored.
REQ-022 WAIT_RESOLVE, resolve_valid and not taken -> IDLE next cycle; no flush, no redirect.
REQ-023 WAIT_RESOLVE, resolve_valid and taken -> FLUSH; redirect_valid=1 for exactly the first FLUSH cycle, redirect_pc=resolve_target captured on that edge.
REQ-024 FLUSH: flush=1 and stall_fetch=1 for exactly FLUSH_CYCLES cycles via down-counter, then IDLE.
REQ-025 FLUSH: inst_valid and resolve_valid ignored.
REQ-026 Latency: branch accepted at edge N -> stall_fetch=1 from cycle N+1; resolve at edge M -> stall_fetch=0 from M+1 (not taken) or M+1+FLUSH_CYCLES (taken).
REQ-027 Back-to-back: a branch presented in the first IDLE cycle after WAIT_RESOLVE/FLUSH is accepted.
REQ-028 redirect_pc and branch_pc hold last value outside their update events.

Reset
REQ-029 Reset assertion forces IDLE immediately, regardless of state, including mid-WAIT_RESOLVE or mid-FLUSH.
REQ-030 Reset values: stall_fetch=0, flush=0, redirect_valid=0, redirect_pc=0, branch_pc=0, flush counter=0.
REQ-031 First branch accepted on first rising edge with reset deasserted.

Configuration
REQ-032 Macro BRANCH_HAZARD_CTRL_PERF_EN adds outputs stall_count (32) and taken_count (32).
REQ-033 With macro: stall_count +1 each cycle stall_fetch=1; taken_count +1 per taken resolve; both saturate at 0xFFFFFFFF, reset to 0.
REQ-034 Without macro: ports and counter logic absent; all other behaviour identical.

Verification
REQ-035 inst=0x48000010 (b) pc=0x100, resolve not taken 3 cycles later -> stall_fetch=1 for 3 cycles, branch_pc=0x100, flush never 1.
REQ-036 bc at pc=0x200, resolve taken target 0x400 -> redirect_valid 1-cycle pulse, redirect_pc=0x400, flush=1 for 2 cycles, then IDLE.
REQ-037 Non-branch 0x38600001 (addi) with inst_valid=1, resolve_valid=1 in IDLE -> all outputs stay 0.
REQ-038 Reset asserted during FLUSH cycle 1 -> flush, stall_fetch 0 immediately; next bclr (0x4E800020) accepted normally.
REQ-039 Taken branch, then bcctr (0x4E800420) in first IDLE cycle -> accepted, branch_pc updated, no idle gap.
REQ-040 PERF_EN: 5 taken branches, 4 stall cycles each -> taken_count=5, stall_count=20; forced near 0xFFFFFFFF -> saturates.

Source files
------------

// File: rtl/branch_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl_if
//   Bundles the fetch/execute-facing signals of branch_hazard_ctrl.
//
//   master modport : pipeline side (drives fetch and resolve inputs,
//                    observes the hazard controls)
//   slave modport  : branch_hazard_ctrl itself
//
//   Signals
//     inst           [31:0]          instruction word from inst_fetch
//     pc             [ADDR_WIDTH-1:0] address of inst
//     inst_valid                     inst/pc valid this cycle
//     resolve_valid                  execute stage reports a branch outcome
//     resolve_taken                  outcome, qualified by resolve_valid
//     resolve_target [ADDR_WIDTH-1:0] taken target, qualified by resolve_valid
//     stall_fetch                    hold fetch PC/instruction
//     flush                          kill younger in-flight instructions
//     redirect_valid                 one-cycle pulse: load redirect_pc
//     redirect_pc    [ADDR_WIDTH-1:0] new fetch address
//     branch_pc      [ADDR_WIDTH-1:0] pc of the outstanding branch
//   With BRANCH_HAZARD_CTRL_PERF_EN defined:
//     stall_count    [31:0]          saturating count of stalled cycles
//     taken_count    [31:0]          saturating count of taken resolves
// -----------------------------------------------------------------------------
interface branch_hazard_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [31:0]           inst;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  inst_valid;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic [ADDR_WIDTH-1:0] resolve_target;
  logic                  stall_fetch;
  logic                  flush;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] branch_pc;
`ifdef BRANCH_HAZARD_CTRL_PERF_EN
  logic [31:0]           stall_count;
  logic [31:0]           taken_count;
`endif

  modport master (
    output inst, pc, inst_valid, resolve_valid, resolve_taken, resolve_target,
    input  stall_fetch, flush, redirect_valid, redirect_pc, branch_pc
`ifdef BRANCH_HAZARD_CTRL_PERF_EN
    , input stall_count, taken_count
`endif
  );

  modport slave (
    input  inst, pc, inst_valid, resolve_valid, resolve_taken, resolve_target,
    output stall_fetch, flush, redirect_valid, redirect_pc, branch_pc
`ifdef BRANCH_HAZARD_CTRL_PERF_EN
    , output stall_count, taken_count
`endif
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//   Control-hazard unit for an in-order pipeline. When fetch presents a
//   branch, the controller records its pc and stalls fetch until execute
//   resolves it. A not-taken branch releases fetch immediately; a taken
//   branch pulses a redirect to the resolved target and holds flush (with
//   stall) for FLUSH_CYCLES cycles. All outputs are registered.
//
//   Parameters
//     ADDR_WIDTH    width of pc / target addresses (default 32)
//     FLUSH_CYCLES  cycles flush is held after a taken branch, 1..15
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    branch_hazard_ctrl_if.slave (see interface file)
//
//   Optional feature
//     Define BRANCH_HAZARD_CTRL_PERF_EN to add the saturating 32-bit
//     stall_count / taken_count performance counters on the interface.
// -----------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RESOLVE = 2'd1,
    FLUSH        = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  // PowerPC numbers instruction bits MSB-first: inst[0:5] is the primary
  // opcode (bits 31:26 here) and inst[21:30] is the extended opcode
  // (bits 10:1 here).
  localparam logic [5:0] OP_B     = 6'd18;
  localparam logic [5:0] OP_BC    = 6'd16;
  localparam logic [5:0] OP_XL    = 6'd19;
  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic                  flush_q, flush_d;
  logic                  redir_v_q, redir_v_d;
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [ADDR_WIDTH-1:0] branch_pc_q, branch_pc_d;
  logic                  taken_evt;

  logic [5:0]            opcode;
  logic [9:0]            xo;
  logic                  is_branch;
  logic                  unused_inst_bits;

  // ---------------------------------------------------------------------------
  // Branch decode
  // ---------------------------------------------------------------------------
  always_comb begin
    opcode    = bus.inst[31:26];
    xo        = bus.inst[10:1];
    is_branch = (opcode == OP_B) || (opcode == OP_BC) ||
                ((opcode == OP_XL) && ((xo == XO_BCLR) || (xo == XO_BCCTR)));
  end

  assign unused_inst_bits = ^{bus.inst[25:11], bus.inst[0]};

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed for the cycle
  // after the edge so that every output comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    redir_v_d   = 1'b0;
    redir_pc_d  = redir_pc_q;
    branch_pc_d = branch_pc_q;
    taken_evt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.inst_valid && is_branch) begin
          state_d     = WAIT_RESOLVE;
          branch_pc_d = bus.pc;
          stall_d     = 1'b1;
        end
      end

      WAIT_RESOLVE: begin
        stall_d = 1'b1;
        if (bus.resolve_valid) begin
          if (bus.resolve_taken) begin
            state_d    = FLUSH;
            cnt_d      = FLUSH_LOAD;
            flush_d    = 1'b1;
            redir_v_d  = 1'b1;
            redir_pc_d = bus.resolve_target;
            taken_evt  = 1'b1;
          end else begin
            state_d = IDLE;
            stall_d = 1'b0;
          end
        end
      end

      FLUSH: begin
        // cnt_q holds the number of flush cycles left including this one.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          stall_d = 1'b1;
          flush_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      redir_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      branch_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      redir_v_q   <= redir_v_d;
      redir_pc_q  <= redir_pc_d;
      branch_pc_q <= branch_pc_d;
    end
  end

  assign bus.stall_fetch    = stall_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redir_v_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.branch_pc      = branch_pc_q;

`ifdef BRANCH_HAZARD_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters. stall_count follows the registered
  // stall_fetch so it counts exactly the cycles the pipeline saw a stall.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_count_q;
  logic [31:0] taken_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      taken_count_q <= '0;
    end else begin
      if (stall_q && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (taken_evt && (taken_count_q != '1)) begin
        taken_count_q <= taken_count_q + 32'd1;
      end
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.taken_count = taken_count_q;
`else
  logic unused_taken_evt;
  assign unused_taken_evt = taken_evt;
`endif

endmodule
